dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of data words on both requester ports and the memory port.
REQ-002 Parameter ADDR_WIDTH, default 8, SHALL set the width of word addresses on both requester ports and the memory port.
REQ-003 Ports SHALL be as follows; requester N is 0 or 1:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- reqN_valid  in  1  requester N has a pending access.
- reqN_we  in  1  1 = write, 0 = read.
- reqN_addr  in  ADDR_WIDTH  word address.
- reqN_wdata  in  DATA_WIDTH  write data.
- reqN_ready  out  1  request accepted in this cycle.
- rspN_valid  out  1  one-cycle completion pulse.
- rspN_rdata  out  DATA_WIDTH  read data; zero for a write.
- mem_address  out  ADDR_WIDTH  drives the DataMemory address.
- mem_writeData  out  DATA_WIDTH  drives the DataMemory writeData.
- mem_writeEnable  out  1  drives the DataMemory writeEnable.
- mem_readData  in  DATA_WIDTH  combinational read data from the DataMemory.

Function
REQ-004 The FSM SHALL have exactly two states: IDLE and ACCESS.
REQ-005 In IDLE with at least one reqN_valid high, the arbiter SHALL do all of the following:
- pick one winner;
- assert that requester's reqN_ready combinationally in the same cycle;
- latch its we, addr and wdata and its id at the clock edge;
- move to ACCESS.
REQ-006 reqN_ready SHALL be 0 in ACCESS, 0 for the losing requester, and never high for both requesters in one cycle.
REQ-007 Arbitration SHALL be round-robin:
- if only one requester is valid, it wins;
- if both are valid, the requester not granted last wins;
- the last-grant pointer updates on every accepted request.
REQ-008 mem_address and mem_writeData SHALL always reflect the latched registers; mem_writeEnable SHALL be high only in ACCESS with latched we=1.
REQ-009 The ACCESS state SHALL last exactly one cycle and then return to IDLE.
REQ-010 On the ACCESS-exit edge, rspN_valid SHALL be registered high for exactly one cycle for the latched id. rspN_rdata SHALL capture mem_readData for a read and 0 for a write.
REQ-011 rspN_rdata SHALL hold its value until the next response to that requester.
REQ-012 Latency and throughput:
- accept-to-response latency SHALL be 2 cycles;
- sustained throughput SHALL be one access per 2 cycles;
- a new request MAY be accepted in the same cycle that rspN_valid is high.
REQ-013 Requesters SHALL hold valid and all request fields stable until ready. Changes to reqN_* during ACCESS SHALL NOT affect the in-flight access.
REQ-014 A requester deasserting valid before ready SHALL withdraw its request without side effects.
REQ-015 A read to an address written by the immediately preceding access SHALL return the new data.

Reset
REQ-016 While rst=0, outputs SHALL be forced asynchronously as follows:
- state=IDLE;
- latched we/addr/wdata/id=0;
- mem_writeEnable=0, mem_address=0, mem_writeData=0;
- reqN_ready=0, rspN_valid=0, rspN_rdata=0.
REQ-017 Reset release SHALL set the last-grant pointer so that requester 0 wins the first tie.
REQ-018 Reset asserted during ACCESS SHALL abort the access with the following results:
- mem_writeEnable drops immediately;
- no response pulse is generated;
- the aborted requester SHALL re-issue after reset.
REQ-019 Both reqN_ready outputs SHALL stay 0 on the first post-reset edge only if rst is still low at that edge.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset then write: rst low 2 cycles, release; req0 write addr 0x00 data 0x11223344 -> req0_ready in cycle 0; mem_writeEnable=1, mem_address=0x00 in cycle 1; rsp0_valid=1, rsp0_rdata=0 in cycle 2.
- Read back: req0 read addr 0x00 after the above -> rsp0_valid 2 cycles after ready, rsp0_rdata=0x11223344; rsp1_valid stays 0.
- Tie after reset: both valid continuously, req0 write 0x05 = 0xAABBCCDD, req1 read 0x05 -> req0 granted first, req1 second; rsp1_rdata=0xAABBCCDD; grants then alternate 0,1,0,1 with no requester granted twice in a row.
- Single requester streaming: req1 alone issues 4 reads at addrs 0x10..0x13 -> ready every other cycle; 4 rsp1_valid pulses in order.
- Mid-access reset: drop rst during ACCESS of a req1 write to 0x20 = 0xDEADBEEF -> mem_writeEnable=0 the same cycle; no rsp1_valid; all outputs 0 until release.
- Withdrawal: req1_valid high for one cycle while ACCESS serves req0, then low -> req1 never receives ready or a response.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port DataMemory.
// Each accepted request takes one ACCESS cycle; a response pulse follows on the next cycle.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,

  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,

  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writeData,
  output logic                  mem_writeEnable,
  input  logic [DATA_WIDTH-1:0] mem_readData
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  lat_we_q, lat_we_d;
  logic                  lat_id_q, lat_id_d;
  logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_WIDTH-1:0] lat_wdata_q, lat_wdata_d;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic [DATA_WIDTH-1:0] rsp1_rdata_q, rsp1_rdata_d;

  logic gnt0, gnt1, accept;

  // Grants are gated by rst so ready is forced low for the whole reset window.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst && (state_q == IDLE)) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign accept = gnt0 | gnt1;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req0_ready      = gnt0;
    req1_ready      = gnt1;
    mem_address     = lat_addr_q;
    mem_writeData   = lat_wdata_q;
    mem_writeEnable = (state_q == ACCESS) && lat_we_q;
    rsp0_valid      = rsp0_valid_q;
    rsp1_valid      = rsp1_valid_q;
    rsp0_rdata      = rsp0_rdata_q;
    rsp1_rdata      = rsp1_rdata_q;
  end

  // Request latch, grant pointer and response capture
  always_comb begin
    lat_we_d    = lat_we_q;
    lat_id_d    = lat_id_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    last_d      = last_q;
    if (accept) begin
      lat_id_d    = gnt1;
      lat_we_d    = gnt1 ? req1_we    : req0_we;
      lat_addr_d  = gnt1 ? req1_addr  : req0_addr;
      lat_wdata_d = gnt1 ? req1_wdata : req0_wdata;
      last_d      = gnt1;
    end

    rsp0_valid_d = (state_q == ACCESS) && !lat_id_q;
    rsp1_valid_d = (state_q == ACCESS) &&  lat_id_q;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
    if (rsp0_valid_d) rsp0_rdata_d = lat_we_q ? '0 : mem_readData;
    if (rsp1_valid_d) rsp1_rdata_d = lat_we_q ? '0 : mem_readData;
  end

  // last_q resets to requester 1 so that requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q       <= 1'b1;
      lat_we_q     <= 1'b0;
      lat_id_q     <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      last_q       <= last_d;
      lat_we_q     <= lat_we_d;
      lat_id_q     <= lat_id_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural DataMemory (sync write, comb read).
// Unwritten locations read back a fixed address-derived pattern.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_we, req0_ready, rsp0_valid;
  logic [7:0]  req0_addr;
  logic [31:0] req0_wdata, rsp0_rdata;
  logic        req1_valid, req1_we, req1_ready, rsp1_valid;
  logic [7:0]  req1_addr;
  logic [31:0] req1_wdata, rsp1_rdata;
  logic [7:0]  mem_address;
  logic [31:0] mem_writeData, mem_readData;
  logic        mem_writeEnable;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] mem [256];
  bit          written [256];

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_writeEnable(mem_writeEnable), .mem_readData(mem_readData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(input logic [7:0] a);
    return {8'hA5, 16'h0000, a};
  endfunction

  always @(posedge clk) begin
    if (mem_writeEnable) begin
      mem[mem_address]     <= mem_writeData;
      written[mem_address] <= 1'b1;
    end
  end

  always_comb mem_readData = written[mem_address] ? mem[mem_address] : dflt(mem_address);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic v, input logic we, input logic [7:0] a, input logic [31:0] d);
    req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
  endtask

  task automatic drv1(input logic v, input logic we, input logic [7:0] a, input logic [31:0] d);
    req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
  endtask

  initial begin
    rst = 1'b0;
    drv0(1'b1, 1'b0, 8'h00, 32'h0);
    drv1(1'b0, 1'b0, 8'h00, 32'h0);

    // Reset: everything held low even with a pending request
    @(negedge clk); #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_memwe", mem_writeEnable, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_rsp0v", rsp0_valid, 0);
    chk("rst_rsp0d", rsp0_rdata, 0);
    @(negedge clk); #1;
    chk("rst_ready0_2", req0_ready, 0);

    // Reset then write
    @(negedge clk); rst = 1'b1; drv0(1'b1, 1'b1, 8'h00, 32'h11223344); #1;
    chk("wr_ready0", req0_ready, 1);
    chk("wr_ready1", req1_ready, 0);
    @(negedge clk); drv0(1'b0, 1'b0, 8'h00, 32'h0); #1;
    chk("wr_memwe", mem_writeEnable, 1);
    chk("wr_addr", mem_address, 8'h00);
    chk("wr_wdata", mem_writeData, 32'h11223344);
    chk("wr_acc_ready0", req0_ready, 0);

    // Read back, accepted in the same cycle as the write response
    @(negedge clk); drv0(1'b1, 1'b0, 8'h00, 32'h0); #1;
    chk("wr_rsp0v", rsp0_valid, 1);
    chk("wr_rsp0d", rsp0_rdata, 0);
    chk("rd_ready0", req0_ready, 1);
    @(negedge clk); drv0(1'b0, 1'b0, 8'h00, 32'h0); #1;
    chk("rd_memwe", mem_writeEnable, 0);
    chk("rd_rsp0v_gap", rsp0_valid, 0);
    @(negedge clk); #1;
    chk("rd_rsp0v", rsp0_valid, 1);
    chk("rd_rsp0d", rsp0_rdata, 32'h11223344);
    chk("rd_rsp1v", rsp1_valid, 0);
    @(negedge clk); #1;
    chk("rd_rsp0v_drop", rsp0_valid, 0);

    // Tie after reset: both valid continuously, grants alternate starting with 0
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    drv0(1'b1, 1'b1, 8'h05, 32'hAABBCCDD);
    drv1(1'b1, 1'b0, 8'h05, 32'h0);
    #1;
    for (int g = 0; g < 6; g++) begin
      if (g > 0) begin
        @(negedge clk); #1;
        chk("tie_rsp0v", rsp0_valid, ((g - 1) % 2 == 0));
        chk("tie_rsp1v", rsp1_valid, ((g - 1) % 2 == 1));
        if ((g - 1) % 2 == 1) chk("tie_rsp1d", rsp1_rdata, 32'hAABBCCDD);
      end
      chk("tie_ready0", req0_ready, (g % 2 == 0));
      chk("tie_ready1", req1_ready, (g % 2 == 1));
      @(negedge clk); #1;
      chk("tie_acc_ready0", req0_ready, 0);
      chk("tie_acc_ready1", req1_ready, 0);
      chk("tie_memwe", mem_writeEnable, (g % 2 == 0));
    end
    @(negedge clk);
    drv0(1'b0, 1'b0, 8'h00, 32'h0);
    drv1(1'b0, 1'b0, 8'h00, 32'h0);
    #1;
    chk("tie_last_rsp1v", rsp1_valid, 1);
    chk("tie_last_rsp1d", rsp1_rdata, 32'hAABBCCDD);
    chk("tie_idle_ready0", req0_ready, 0);

    // Single requester streaming reads; next request presented during ACCESS
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drv1(1'b1, 1'b0, 8'(8'h10 + i), 32'h0); #1;
      chk("st_ready1", req1_ready, 1);
      if (i > 0) begin
        chk("st_rsp1v", rsp1_valid, 1);
        chk("st_rsp1d", rsp1_rdata, dflt(8'(8'h10 + i - 1)));
      end else begin
        chk("st_rsp1v_first", rsp1_valid, 0);
      end
      @(negedge clk);
      if (i < 3) drv1(1'b1, 1'b0, 8'(8'h11 + i), 32'h0);
      else       drv1(1'b0, 1'b0, 8'h00, 32'h0);
      #1;
      chk("st_acc_ready1", req1_ready, 0);
      chk("st_acc_addr", mem_address, 8'(8'h10 + i));
      chk("st_acc_rsp1v", rsp1_valid, 0);
    end
    @(negedge clk); #1;
    chk("st_last_rsp1v", rsp1_valid, 1);
    chk("st_last_rsp1d", rsp1_rdata, dflt(8'h13));

    // Mid-access reset aborts a req1 write
    @(negedge clk); drv1(1'b1, 1'b1, 8'h20, 32'hDEADBEEF); #1;
    chk("mr_ready1", req1_ready, 1);
    @(negedge clk); drv1(1'b0, 1'b0, 8'h00, 32'h0); #1;
    chk("mr_memwe_pre", mem_writeEnable, 1);
    #2; rst = 1'b0; drv0(1'b1, 1'b0, 8'h20, 32'h0); #1;
    chk("mr_memwe", mem_writeEnable, 0);
    chk("mr_addr", mem_address, 0);
    chk("mr_wdata", mem_writeData, 0);
    chk("mr_ready0", req0_ready, 0);
    chk("mr_ready1", req1_ready, 0);
    chk("mr_rsp1v", rsp1_valid, 0);
    chk("mr_rsp1d", rsp1_rdata, 0);
    @(negedge clk); #1;
    chk("mr_rsp1v_edge", rsp1_valid, 0);
    chk("mr_ready0_edge", req0_ready, 0);
    chk("mr_memwe_edge", mem_writeEnable, 0);
    @(negedge clk); rst = 1'b1; #1;
    chk("mr_rd_ready0", req0_ready, 1);
    @(negedge clk); drv0(1'b0, 1'b0, 8'h00, 32'h0); #1;
    chk("mr_rd_memwe", mem_writeEnable, 0);
    @(negedge clk); #1;
    chk("mr_rd_rsp0v", rsp0_valid, 1);
    chk("mr_rd_rsp0d", rsp0_rdata, dflt(8'h20));
    chk("mr_rd_rsp1v", rsp1_valid, 0);

    // Withdrawal: req1 valid for one ACCESS cycle only
    @(negedge clk); drv0(1'b1, 1'b1, 8'h30, 32'h00000055); #1;
    chk("wd_ready0", req0_ready, 1);
    @(negedge clk);
    drv0(1'b0, 1'b0, 8'h00, 32'h0);
    drv1(1'b1, 1'b1, 8'h31, 32'h00000066);
    #1;
    chk("wd_acc_ready1", req1_ready, 0);
    chk("wd_memwe", mem_writeEnable, 1);
    @(negedge clk); drv1(1'b0, 1'b0, 8'h00, 32'h0); #1;
    chk("wd_ready1", req1_ready, 0);
    chk("wd_rsp0v", rsp0_valid, 1);
    chk("wd_rsp1v", rsp1_valid, 0);
    @(negedge clk); #1;
    chk("wd_rsp1v_2", rsp1_valid, 0);
    chk("wd_memwe_2", mem_writeEnable, 0);
    @(negedge clk); drv0(1'b1, 1'b0, 8'h31, 32'h0); #1;
    chk("wd_rd_ready0", req0_ready, 1);
    @(negedge clk); drv0(1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk); #1;
    chk("wd_rd_rsp0d", rsp0_rdata, dflt(8'h31));
    chk("wd_rd_rsp1v", rsp1_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
